// File: rtl/multiport_register_file.sv
// Multiport register file with same-cycle read bypass, a trigger-loaded
// register, a monitor output, and a per-register pending (busy) scoreboard.
// Register 0 is hardwired to zero and can never be busy.
module multiport_register_file #(
  parameter int A_WIDTH  = 5,
  parameter int D_WIDTH  = 32,
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter int TRIG_REG = 5,
  parameter int MON_REG  = 10
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      trigger,
  input  logic [N_WR-1:0]           WE,
  input  logic [N_WR*A_WIDTH-1:0]   WA,
  input  logic [N_WR*D_WIDTH-1:0]   WD,
  input  logic [N_RD*A_WIDTH-1:0]   RA,
  output logic [N_RD*D_WIDTH-1:0]   RD,
  output logic [N_RD-1:0]           RBUSY,
  input  logic                      ALLOC,
  input  logic [A_WIDTH-1:0]        ALLOC_A,
  output logic [D_WIDTH-1:0]        a0
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] regs     [DEPTH];
  logic [D_WIDTH-1:0] nxt      [DEPTH];
  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   busy_nxt;
  logic [DEPTH-1:0]   wr_hit;

  // Next value of every register: trigger beats the highest write port,
  // which beats lower ports, which beat the stored value. Busy is cleared
  // by a port write and set by ALLOC, so a new producer wins a tie.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      nxt[r]      = regs[r];
      wr_hit[r]   = 1'b0;
      busy_nxt[r] = busy[r];
      for (int p = 0; p < N_WR; p++) begin
        if (WE[p] && (WA[p*A_WIDTH +: A_WIDTH] == A_WIDTH'(r))) begin
          nxt[r]      = WD[p*D_WIDTH +: D_WIDTH];
          wr_hit[r]   = 1'b1;
          busy_nxt[r] = 1'b0;
        end
      end
      if (trigger && (r == TRIG_REG)) nxt[r] = D_WIDTH'(1);
      if (ALLOC && (ALLOC_A == A_WIDTH'(r))) busy_nxt[r] = 1'b1;
      if (r == 0) begin
        nxt[r]      = '0;
        wr_hit[r]   = 1'b0;
        busy_nxt[r] = 1'b0;
      end
    end
  end

  // Register and scoreboard state; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= nxt[r];
      busy <= busy_nxt;
    end
  end

  // Combinational read ports and monitor, all showing the bypassed value;
  // forced to zero while reset is held.
  always_comb begin
    RD    = '0;
    RBUSY = '0;
    a0    = '0;
    if (!RST) begin
      for (int i = 0; i < N_RD; i++) begin
        RD[i*D_WIDTH +: D_WIDTH] = nxt[RA[i*A_WIDTH +: A_WIDTH]];
        RBUSY[i] = busy[RA[i*A_WIDTH +: A_WIDTH]] & ~wr_hit[RA[i*A_WIDTH +: A_WIDTH]];
      end
      a0 = nxt[A_WIDTH'(MON_REG)];
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file with default parameters.
module tb_multiport_register_file;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        trigger = 1'b0;
  logic [1:0]  WE = '0;
  logic [9:0]  WA = '0;
  logic [63:0] WD = '0;
  logic [9:0]  RA = '0;
  logic [63:0] RD;
  logic [1:0]  RBUSY;
  logic        ALLOC = 1'b0;
  logic [4:0]  ALLOC_A = '0;
  logic [31:0] a0;
  logic [31:0] rd0, rd1;

  int n_cmp = 0;
  int n_bad = 0;

  assign rd0 = RD[31:0];
  assign rd1 = RD[63:32];

  multiport_register_file dut (
    .CLK(CLK), .RST(RST), .trigger(trigger), .WE(WE), .WA(WA), .WD(WD),
    .RA(RA), .RD(RD), .RBUSY(RBUSY), .ALLOC(ALLOC), .ALLOC_A(ALLOC_A), .a0(a0)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE = '0; trigger = 1'b0; ALLOC = 1'b0;
  endtask

  task automatic test_reset();
    // everything active while reset is held
    WE = 2'b11; WA = {5'd3, 5'd3}; WD = {32'h1111_2222, 32'h3333_4444};
    trigger = 1'b1; ALLOC = 1'b1; ALLOC_A = 5'd10; RA = {5'd10, 5'd3};
    #2;
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL rst_rd0: got %h want %h", rd0, 32'h0); end
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL rst_rd1: got %h want %h", rd1, 32'h0); end
    n_cmp++; if (a0 !== 32'h0) begin n_bad++; $display("FAIL rst_a0: got %h want %h", a0, 32'h0); end
    n_cmp++; if (RBUSY !== 2'b00) begin n_bad++; $display("FAIL rst_rbusy: got %b want %b", RBUSY, 2'b00); end
    step();
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL rst_edge_rd0: got %h want %h", rd0, 32'h0); end
    idle();
  endtask

  task automatic test_reset_release();
    RST = 1'b0;
    WE = 2'b01; WA = {5'd0, 5'd4}; WD = {32'h0, 32'h0000_00A5}; RA = {5'd3, 5'd4};
    #1;
    n_cmp++; if (rd0 !== 32'hA5) begin n_bad++; $display("FAIL rel_bypass: got %h want %h", rd0, 32'hA5); end
    step();
    idle();
    #1;
    n_cmp++; if (rd0 !== 32'hA5) begin n_bad++; $display("FAIL rel_commit: got %h want %h", rd0, 32'hA5); end
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL rel_no_rst_write: got %h want %h", rd1, 32'h0); end
    n_cmp++; if (RBUSY !== 2'b00) begin n_bad++; $display("FAIL rel_no_rst_alloc: got %b want %b", RBUSY, 2'b00); end
  endtask

  task automatic test_write_bypass();
    WE = 2'b01; WA = {5'd0, 5'd3}; WD = {32'h0, 32'hDEAD_BEEF}; RA = {5'd0, 5'd3};
    #1;
    n_cmp++; if (rd0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL byp_same: got %h want %h", rd0, 32'hDEAD_BEEF); end
    step();
    idle();
    #1;
    n_cmp++; if (rd0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL byp_after: got %h want %h", rd0, 32'hDEAD_BEEF); end
  endtask

  task automatic test_port_conflict();
    WE = 2'b11; WA = {5'd7, 5'd7}; WD = {32'h22, 32'h11}; RA = {5'd7, 5'd7};
    #1;
    n_cmp++; if (rd0 !== 32'h22) begin n_bad++; $display("FAIL conf_bypass: got %h want %h", rd0, 32'h22); end
    step();
    idle();
    #1;
    n_cmp++; if (rd1 !== 32'h22) begin n_bad++; $display("FAIL conf_commit: got %h want %h", rd1, 32'h22); end
  endtask

  task automatic test_trigger();
    trigger = 1'b1; WE = 2'b01; WA = {5'd0, 5'd5}; WD = {32'h0, 32'hFF}; RA = {5'd0, 5'd5};
    #1;
    n_cmp++; if (rd0 !== 32'h1) begin n_bad++; $display("FAIL trig_bypass: got %h want %h", rd0, 32'h1); end
    step();
    idle();
    #1;
    n_cmp++; if (rd0 !== 32'h1) begin n_bad++; $display("FAIL trig_commit: got %h want %h", rd0, 32'h1); end
    // write to register 0 is dropped
    WE = 2'b01; WA = {5'd0, 5'd0}; WD = {32'h0, 32'h55}; RA = {5'd0, 5'd0};
    #1;
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL x0_bypass: got %h want %h", rd0, 32'h0); end
    step();
    idle();
    #1;
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL x0_commit: got %h want %h", rd0, 32'h0); end
  endtask

  task automatic test_scoreboard();
    ALLOC = 1'b1; ALLOC_A = 5'd10; RA = {5'd10, 5'd0};
    #1;
    n_cmp++; if (RBUSY !== 2'b00) begin n_bad++; $display("FAIL sb_alloc_same: got %b want %b", RBUSY, 2'b00); end
    step();
    idle();
    #1;
    n_cmp++; if (RBUSY !== 2'b10) begin n_bad++; $display("FAIL sb_busy: got %b want %b", RBUSY, 2'b10); end
    WE = 2'b10; WA = {5'd10, 5'd0}; WD = {32'h2A, 32'h0};
    #1;
    n_cmp++; if (RBUSY !== 2'b00) begin n_bad++; $display("FAIL sb_wr_fwd: got %b want %b", RBUSY, 2'b00); end
    n_cmp++; if (a0 !== 32'h2A) begin n_bad++; $display("FAIL sb_a0_byp: got %h want %h", a0, 32'h2A); end
    step();
    idle();
    #1;
    n_cmp++; if (RBUSY !== 2'b00) begin n_bad++; $display("FAIL sb_cleared: got %b want %b", RBUSY, 2'b00); end
    n_cmp++; if (a0 !== 32'h2A) begin n_bad++; $display("FAIL sb_a0: got %h want %h", a0, 32'h2A); end
    // allocation and write together: busy ends set
    ALLOC = 1'b1; ALLOC_A = 5'd10; WE = 2'b10; WA = {5'd10, 5'd0}; WD = {32'h33, 32'h0};
    step();
    idle();
    #1;
    n_cmp++; if (RBUSY !== 2'b10) begin n_bad++; $display("FAIL sb_alloc_wr: got %b want %b", RBUSY, 2'b10); end
    n_cmp++; if (a0 !== 32'h33) begin n_bad++; $display("FAIL sb_alloc_wr_a0: got %h want %h", a0, 32'h33); end
    // re-allocating a busy register keeps it busy
    ALLOC = 1'b1; ALLOC_A = 5'd10;
    step();
    idle();
    #1;
    n_cmp++; if (RBUSY !== 2'b10) begin n_bad++; $display("FAIL sb_realloc: got %b want %b", RBUSY, 2'b10); end
    // ALLOC of register 0 is ignored
    ALLOC = 1'b1; ALLOC_A = 5'd0;
    step();
    idle();
    #1;
    n_cmp++; if (RBUSY[0] !== 1'b0) begin n_bad++; $display("FAIL sb_x0: got %b want %b", RBUSY[0], 1'b0); end
  endtask

  task automatic test_async_reset();
    ALLOC = 1'b1; ALLOC_A = 5'd10; WE = 2'b01; WA = {5'd0, 5'd10}; WD = {32'h0, 32'h1234};
    RA = {5'd10, 5'd3};
    step();
    idle();
    #1;
    n_cmp++; if (a0 !== 32'h1234) begin n_bad++; $display("FAIL ar_load: got %h want %h", a0, 32'h1234); end
    n_cmp++; if (RBUSY !== 2'b10) begin n_bad++; $display("FAIL ar_busy: got %b want %b", RBUSY, 2'b10); end
    #1;
    RST = 1'b1;
    #1;
    n_cmp++; if (a0 !== 32'h0) begin n_bad++; $display("FAIL ar_a0: got %h want %h", a0, 32'h0); end
    n_cmp++; if (RBUSY !== 2'b00) begin n_bad++; $display("FAIL ar_rbusy: got %b want %b", RBUSY, 2'b00); end
    #1;
    RST = 1'b0;
    #1;
    n_cmp++; if (a0 !== 32'h0) begin n_bad++; $display("FAIL ar_rel_a0: got %h want %h", a0, 32'h0); end
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL ar_rel_r3: got %h want %h", rd0, 32'h0); end
    n_cmp++; if (RBUSY !== 2'b00) begin n_bad++; $display("FAIL ar_rel_busy: got %b want %b", RBUSY, 2'b00); end
    RA = {5'd5, 5'd7};
    #1;
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL ar_rel_r7: got %h want %h", rd0, 32'h0); end
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL ar_rel_r5: got %h want %h", rd1, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_write_bypass();
    test_port_conflict();
    test_trigger();
    test_scoreboard();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
